// File: rtl/dkong_snd_rom_arb.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | Module : dkong_snd_rom_arb                                                         |
// | Brief  : Three-port arbiter sharing the sound sample ROM (CPU fetch, wave player,  |
// |          aux sample player); fixed-latency read with a one-cycle ack per access.   |
// | Config : DKONG_SND_ARB_CPU_PRIO_EN -- port 0 gets absolute priority in IDLE.       |
// | Rev    : 1.0  initial release                                                      |
// +------------------------------------------------------------------------------------+
module dkong_snd_rom_arb #(
  parameter int ROM_LAT = 2,
  parameter int AW      = 19,
  parameter int DW      = 8
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic [2:0]    I_REQ,
  input  logic [AW-1:0] I_ADR0,
  input  logic [AW-1:0] I_ADR1,
  input  logic [AW-1:0] I_ADR2,
  output logic [2:0]    O_ACK,
  output logic [DW-1:0] O_DAT,
  output logic [AW-1:0] O_ROM_AB,
  output logic          O_ROM_OE,
  input  logic [DW-1:0] I_ROM_DB,
  output logic          O_BUSY
);

  localparam logic [3:0] c_LAT = 4'(ROM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rr_ptr;
  logic [2:0]    r_ack;
  logic [DW-1:0] r_dat;
  logic [AW-1:0] r_rom_ab;
  logic          r_rom_oe;
  logic [1:0]    w_win;
  logic          w_upd_rr;
  logic          w_grant;
  logic          w_cap;
  logic [AW-1:0] w_win_adr;
  logic [2:0]    w_gnt_onehot;

`ifdef DKONG_SND_ARB_CPU_PRIO_EN
  // Port 0 always wins; ports 1 and 2 alternate via rr_ptr, which only tracks their grants.
  always_comb begin
    w_win    = 2'd0;
    w_upd_rr = 1'b0;
    if (I_REQ[0]) begin
      w_win    = 2'd0;
      w_upd_rr = 1'b0;
    end else if (r_rr_ptr == 2'd1) begin
      w_win    = I_REQ[2] ? 2'd2 : 2'd1;
      w_upd_rr = 1'b1;
    end else begin
      w_win    = I_REQ[1] ? 2'd1 : 2'd2;
      w_upd_rr = 1'b1;
    end
  end
`else
  function automatic logic [1:0] nxt3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] req, input logic [1:0] idx);
    case (idx)
      2'd0:    return req[0];
      2'd1:    return req[1];
      default: return req[2];
    endcase
  endfunction

  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Search rr_ptr+1, rr_ptr+2, then rr_ptr itself.
  always_comb begin
    w_c1     = nxt3(r_rr_ptr);
    w_c2     = nxt3(w_c1);
    w_upd_rr = 1'b1;
    if (req_at(I_REQ, w_c1))      w_win = w_c1;
    else if (req_at(I_REQ, w_c2)) w_win = w_c2;
    else                          w_win = r_rr_ptr;
  end
`endif

  always_comb begin
    w_win_adr    = I_ADR0;
    w_gnt_onehot = 3'b001;
    case (w_win)
      2'd0:    w_win_adr = I_ADR0;
      2'd1:    w_win_adr = I_ADR1;
      default: w_win_adr = I_ADR2;
    endcase
    case (r_gnt)
      2'd0:    w_gnt_onehot = 3'b001;
      2'd1:    w_gnt_onehot = 3'b010;
      default: w_gnt_onehot = 3'b100;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|I_REQ) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_cnt    <= 4'd0;
      r_gnt    <= 2'd0;
      r_rr_ptr <= 2'd2;
      r_ack    <= 3'b000;
      r_dat    <= '0;
      r_rom_ab <= '0;
      r_rom_oe <= 1'b0;
    end else begin
      r_ack <= 3'b000;
      if (w_grant) begin
        r_rom_ab <= w_win_adr;
        r_rom_oe <= 1'b1;
        r_gnt    <= w_win;
        r_cnt    <= c_LAT;
        if (w_upd_rr) r_rr_ptr <= w_win;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        // Address stays on the bus after capture; only OE drops.
        if (w_cap) begin
          r_dat    <= I_ROM_DB;
          r_ack    <= w_gnt_onehot;
          r_rom_oe <= 1'b0;
        end
      end
    end
  end

  assign O_ACK    = r_ack;
  assign O_DAT    = r_dat;
  assign O_ROM_AB = r_rom_ab;
  assign O_ROM_OE = r_rom_oe;
  assign O_BUSY   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dkong_snd_rom_arb.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | Module : tb_dkong_snd_rom_arb                                                      |
// | Brief  : Directed bench for dkong_snd_rom_arb at ROM_LAT 2, 1 and 15.              |
// | Rev    : 1.0  initial release                                                      |
// +------------------------------------------------------------------------------------+
module tb_dkong_snd_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [18:0] a);
    if (a == 19'h14800) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  // main instance, ROM_LAT=2
  logic [2:0]  req_m;
  logic [18:0] a0_m, a1_m, a2_m, ab_m;
  logic [2:0]  ack_m;
  logic [7:0]  dat_m, db_m;
  logic        oe_m, busy_m;
  int          age_m = 0;
  // ROM model returns poison until ROM_LAT cycles after OE rises.
  always @(posedge clk) age_m <= oe_m ? age_m + 1 : 0;
  assign db_m = (oe_m && age_m >= 1) ? rom_fn(ab_m) : 8'hEE;

  dkong_snd_rom_arb #(.ROM_LAT(2), .AW(19), .DW(8)) u_dut (
    .I_CLK(clk), .I_RST(rst), .I_REQ(req_m), .I_ADR0(a0_m), .I_ADR1(a1_m), .I_ADR2(a2_m),
    .O_ACK(ack_m), .O_DAT(dat_m), .O_ROM_AB(ab_m), .O_ROM_OE(oe_m), .I_ROM_DB(db_m),
    .O_BUSY(busy_m));

  // ROM_LAT=1 instance
  logic [2:0]  req_1;
  logic [18:0] a0_1, a1_1, a2_1, ab_1;
  logic [2:0]  ack_1;
  logic [7:0]  dat_1, db_1;
  logic        oe_1, busy_1;
  assign db_1 = oe_1 ? rom_fn(ab_1) : 8'hEE;

  dkong_snd_rom_arb #(.ROM_LAT(1), .AW(19), .DW(8)) u_l1 (
    .I_CLK(clk), .I_RST(rst), .I_REQ(req_1), .I_ADR0(a0_1), .I_ADR1(a1_1), .I_ADR2(a2_1),
    .O_ACK(ack_1), .O_DAT(dat_1), .O_ROM_AB(ab_1), .O_ROM_OE(oe_1), .I_ROM_DB(db_1),
    .O_BUSY(busy_1));

  // ROM_LAT=15 instance
  logic [2:0]  req_f;
  logic [18:0] a0_f, a1_f, a2_f, ab_f;
  logic [2:0]  ack_f;
  logic [7:0]  dat_f, db_f;
  logic        oe_f, busy_f;
  int          age_f = 0;
  always @(posedge clk) age_f <= oe_f ? age_f + 1 : 0;
  assign db_f = (oe_f && age_f >= 14) ? rom_fn(ab_f) : 8'hEE;

  dkong_snd_rom_arb #(.ROM_LAT(15), .AW(19), .DW(8)) u_l15 (
    .I_CLK(clk), .I_RST(rst), .I_REQ(req_f), .I_ADR0(a0_f), .I_ADR1(a1_f), .I_ADR2(a2_f),
    .O_ACK(ack_f), .O_DAT(dat_f), .O_ROM_AB(ab_f), .O_ROM_OE(oe_f), .I_ROM_DB(db_f),
    .O_BUSY(busy_f));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle: at most one ack bit, and never an ack while OE is high.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_invariant", {31'd0, $onehot0(ack_m) && !(|ack_m && oe_m)}, 32'd1);
  endtask

  task automatic wait_ack(input int sel, input int budget, output logic [2:0] a,
                          output logic [7:0] d, output int n);
    n = 0;
    a = 3'b000;
    d = 8'h00;
    while (n < budget) begin
      tick();
      n++;
      a = (sel == 0) ? ack_m : (sel == 1) ? ack_1 : ack_f;
      d = (sel == 0) ? dat_m : (sel == 1) ? dat_1 : dat_f;
      if (a != 3'b000) break;
    end
  endtask

  task automatic expect_ack(input string tag, input int sel, input int port, input int exp_n,
                            input logic [18:0] addr);
    logic [2:0] a;
    logic [7:0] d;
    int         n;
    wait_ack(sel, 40, a, d, n);
    chk({tag, "_ack"}, {29'd0, a}, 32'd1 << port);
    chk({tag, "_cycles"}, n, exp_n);
    chk({tag, "_dat"}, {24'd0, d}, {24'd0, rom_fn(addr)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [18:0] cadr [3];
  int          seq [9];

  initial begin
    rst = 1'b0;
    req_m = 3'b000; a0_m = '0; a1_m = '0; a2_m = '0;
    req_1 = 3'b000; a0_1 = '0; a1_1 = '0; a2_1 = '0;
    req_f = 3'b000; a0_f = '0; a1_f = '0; a2_f = '0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_ack", {29'd0, ack_m}, 32'd0);
    chk("rst_dat", {24'd0, dat_m}, 32'd0);
    chk("rst_ab", {13'd0, ab_m}, 32'd0);
    chk("rst_oe", {31'd0, oe_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    rst = 1'b0;
    tick();

    // Single read on port 1; address is changed after it has been latched.
    req_m = 3'b010; a1_m = 19'h14800;
    tick();
    chk("t1_ab", {13'd0, ab_m}, 32'h14800);
    chk("t1_oe", {31'd0, oe_m}, 32'd1);
    chk("t1_busy", {31'd0, busy_m}, 32'd1);
    a1_m = 19'h00777;
    tick();
    chk("t1_noack", {29'd0, ack_m}, 32'd0);
    tick();
    chk("t1_ack", {29'd0, ack_m}, 32'b010);
    chk("t1_dat", {24'd0, dat_m}, 32'hA5);
    chk("t1_oe_ack", {31'd0, oe_m}, 32'd0);
    req_m = 3'b000;
    tick();
    chk("t1_ack_clr", {29'd0, ack_m}, 32'd0);
    chk("t1_idle", {31'd0, busy_m}, 32'd0);
    chk("t1_ab_held", {13'd0, ab_m}, 32'h14800);

    // One-cycle request pulse on port 2.
    a2_m = 19'h13abc;
    req_m = 3'b100;
    tick();
    req_m = 3'b000;
    expect_ack("t4", 0, 2, 2, 19'h13abc);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_quiet_ack", {29'd0, ack_m}, 32'd0);
      chk("t4_quiet_busy", {31'd0, busy_m}, 32'd0);
    end

    // Reset in the middle of an access.
    a1_m = 19'h05555;
    req_m = 3'b010;
    tick();
    tick();
    chk("t5_inflight_oe", {31'd0, oe_m}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_oe", {31'd0, oe_m}, 32'd0);
    chk("t5_ack", {29'd0, ack_m}, 32'd0);
    chk("t5_dat", {24'd0, dat_m}, 32'd0);
    chk("t5_busy", {31'd0, busy_m}, 32'd0);
    req_m = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_ack", {29'd0, ack_m}, 32'd0);

    // Three-way contention held continuously, then port 0 withdraws.
    cadr[0] = 19'h00010; cadr[1] = 19'h11000; cadr[2] = 19'h13000;
    a0_m = cadr[0]; a1_m = cadr[1]; a2_m = cadr[2];
`ifdef DKONG_SND_ARB_CPU_PRIO_EN
    seq = '{0, 0, 0, 0, 0, 0, 1, 2, 1};
`else
    seq = '{0, 1, 2, 0, 1, 2, 1, 2, 1};
`endif
    req_m = 3'b111;
    for (int i = 0; i < 6; i++)
      expect_ack($sformatf("t2_%0d", i), 0, seq[i], (i == 0) ? 3 : 4, cadr[seq[i]]);
    req_m = 3'b110;
    for (int i = 6; i < 9; i++)
      expect_ack($sformatf("t3_%0d", i), 0, seq[i], 4, cadr[seq[i]]);
    req_m = 3'b000;
    tick(); tick();
    chk("t3_idle", {31'd0, busy_m}, 32'd0);

    // Latency sweep at ROM_LAT=1 and ROM_LAT=15.
    a0_1 = 19'h2a5c3;
    req_1 = 3'b001;
    expect_ack("t6_l1", 1, 0, 2, 19'h2a5c3);
    req_1 = 3'b000;
    a2_f = 19'h7f00e;
    req_f = 3'b100;
    expect_ack("t6_l15", 2, 2, 16, 19'h7f00e);
    req_f = 3'b000;
    tick();
    chk("t6_l15_idle", {31'd0, busy_f}, 32'd0);
    chk("t6_l1_idle", {31'd0, busy_1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
